// File: rtl/dff_pipe_async_rst_n_vr.sv
// dff_pipe_async_rst_n_vr: elastic valid/ready register pipeline with bubble collapsing, flush and occupancy.
// Define DFF_PIPE_DATA_RST_EN to give the data registers an asynchronous reset to zero.
module dff_pipe_async_rst_n_vr #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             async_rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LW-1:0]    level
);
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] move;
    logic [DEPTH:0]   ld;
    logic [DEPTH-1:0] take;
    logic [DEPTH-1:0] dtake;
    logic [WIDTH-1:0] d   [DEPTH];
    logic [WIDTH-1:0] src [DEPTH];

    // Load/move chain resolved from the output stage back towards the input stage.
    always_comb begin
        ld = '0;
        move = '0;
        ld[DEPTH] = out_ready && !flush;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            move[i] = v[i] && ld[i+1];
            ld[i] = !v[i] || move[i];
        end
    end

    // Per-stage sources: stage 0 takes the producer, later stages take their predecessor.
    always_comb begin
        take = '0;
        dtake = '0;
        src[0] = in_data;
        take[0] = in_valid && in_ready;
        dtake[0] = in_valid;
        for (int i = 1; i < DEPTH; i++) begin
            src[i] = d[i-1];
            take[i] = move[i-1];
            dtake[i] = move[i-1];
        end
    end

    // Occupancy is the population count of the valid bits.
    always_comb begin
        level = '0;
        for (int i = 0; i < DEPTH; i++) level = level + LW'(v[i]);
    end

    assign in_ready  = ld[0] && !flush && async_rst_n;
    assign out_valid = v[DEPTH-1] && !flush;
    assign out_data  = d[DEPTH-1];

    // Valid bits: cleared by reset or flush, otherwise refilled on every loading stage.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) v <= '0;
        else if (flush) v <= '0;
        else for (int i = 0; i < DEPTH; i++) if (ld[i]) v[i] <= take[i];
    end

`ifdef DFF_PIPE_DATA_RST_EN
    // Data registers with reset; flush leaves them untouched.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        else for (int i = 0; i < DEPTH; i++) if (ld[i] && dtake[i]) d[i] <= src[i];
    end
`else
    // Data registers without reset; only valid bits qualify their contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) if (ld[i] && dtake[i]) d[i] <= src[i];
    end
`endif
endmodule

// File: tb/tb_dff_pipe_async_rst_n_vr.sv
// tb_dff_pipe_async_rst_n_vr: directed checks on a DEPTH=3 pipeline plus a scoreboarded DEPTH=1 random run.
module tb_dff_pipe_async_rst_n_vr;
    logic       clk = 1'b0;
    logic       async_rst_n;
    logic       flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [1:0] level;
    logic       iv1, ir1, ov1, or1;
    logic [7:0] id1, od1;
    logic [0:0] lv1;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] q[$];
    logic [7:0] exp_d;

    always #5 clk = ~clk;

    dff_pipe_async_rst_n_vr #(.WIDTH(8), .DEPTH(3)) dut (
        .clk(clk), .async_rst_n(async_rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .level(level)
    );

    dff_pipe_async_rst_n_vr #(.WIDTH(8), .DEPTH(1)) dut1 (
        .clk(clk), .async_rst_n(async_rst_n), .flush(1'b0),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .level(lv1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid = iv;
        in_data = id;
        out_ready = ordy;
        flush = fl;
        #1;
    endtask

    initial begin
        async_rst_n = 1'b0;
        flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
        iv1 = 0; id1 = 0; or1 = 0;
        #3;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_level", level, 0);
`ifdef DFF_PIPE_DATA_RST_EN
        chk("rst_out_data", out_data, 0);
`endif
        @(negedge clk);
        async_rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // streaming with out_ready high
        drive(1, 8'h11, 1, 0); chk("s_c0_ready", in_ready, 1); chk("s_c0_ov", out_valid, 0);
        drive(1, 8'h22, 1, 0); chk("s_c1_ov", out_valid, 0);
        drive(1, 8'h33, 1, 0); chk("s_c2_ov", out_valid, 0);
        drive(0, 8'h00, 1, 0); chk("s_c3_ov", out_valid, 1); chk("s_c3_d", out_data, 8'h11); chk("s_c3_lvl", level, 3);
        drive(0, 8'h00, 1, 0); chk("s_c4_ov", out_valid, 1); chk("s_c4_d", out_data, 8'h22); chk("s_c4_lvl", level, 2);
        drive(0, 8'h00, 1, 0); chk("s_c5_ov", out_valid, 1); chk("s_c5_d", out_data, 8'h33); chk("s_c5_lvl", level, 1);
        drive(0, 8'h00, 1, 0); chk("s_c6_ov", out_valid, 0); chk("s_c6_lvl", level, 0);

        // backpressure, then simultaneous drain and fill
        drive(1, 8'hA0, 0, 0); chk("b_c0_ready", in_ready, 1);
        drive(1, 8'hA1, 0, 0); chk("b_c1_ready", in_ready, 1);
        drive(1, 8'hA2, 0, 0); chk("b_c2_ready", in_ready, 1);
        drive(1, 8'hA3, 0, 0); chk("b_full_ready", in_ready, 0); chk("b_full_lvl", level, 3); chk("b_full_d", out_data, 8'hA0);
        drive(1, 8'hA3, 1, 0); chk("b_df_ready", in_ready, 1); chk("b_df_d", out_data, 8'hA0); chk("b_df_lvl", level, 3);
        drive(1, 8'hA4, 1, 0); chk("b_c5_ready", in_ready, 1); chk("b_c5_d", out_data, 8'hA1); chk("b_c5_lvl", level, 3);
        drive(0, 8'h00, 1, 0); chk("b_c6_d", out_data, 8'hA2); chk("b_c6_lvl", level, 3);
        drive(0, 8'h00, 1, 0); chk("b_c7_d", out_data, 8'hA3); chk("b_c7_ov", out_valid, 1);
        drive(0, 8'h00, 1, 0); chk("b_c8_d", out_data, 8'hA4); chk("b_c8_ov", out_valid, 1);
        drive(0, 8'h00, 1, 0); chk("b_c9_ov", out_valid, 0); chk("b_c9_lvl", level, 0);

        // flush with two beats held
        drive(1, 8'hB0, 0, 0);
        drive(1, 8'hB1, 0, 0);
        drive(1, 8'hB2, 1, 1); chk("f_ready", in_ready, 0); chk("f_ov", out_valid, 0); chk("f_lvl", level, 2);
        drive(1, 8'hC0, 1, 0); chk("f_after_lvl", level, 0); chk("f_after_ov", out_valid, 0); chk("f_after_ready", in_ready, 1);
        drive(0, 8'h00, 1, 0); chk("f_l1_ov", out_valid, 0);
        drive(0, 8'h00, 1, 0); chk("f_l2_ov", out_valid, 0);
        drive(0, 8'h00, 1, 0); chk("f_l3_ov", out_valid, 1); chk("f_l3_d", out_data, 8'hC0);
        drive(0, 8'h00, 1, 0); chk("f_l4_ov", out_valid, 0);

        // asynchronous reset with a full pipeline
        drive(1, 8'hD0, 0, 0);
        drive(1, 8'hD1, 0, 0);
        drive(1, 8'hD2, 0, 0);
        drive(0, 8'h00, 0, 0); chk("r_pre_lvl", level, 3);
        #2 async_rst_n = 1'b0;
        #1;
        chk("r_ov", out_valid, 0);
        chk("r_ready", in_ready, 0);
        chk("r_lvl", level, 0);
`ifdef DFF_PIPE_DATA_RST_EN
        chk("r_d", out_data, 0);
`endif
        @(negedge clk);
        async_rst_n = 1'b1;
        #1;
        chk("r_rel_ready", in_ready, 1);
        chk("r_rel_lvl", level, 0);

        // DEPTH=1 random traffic against a queue model
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            iv1 = 1'($urandom_range(0, 1));
            or1 = 1'($urandom_range(0, 1));
            id1 = 8'($urandom);
            #1;
            chk("d1_lvl", lv1, 32'(q.size()));
            chk("d1_ready", ir1, (q.size() == 0 || or1) ? 1 : 0);
            if (ov1 && or1) begin
                exp_d = (q.size() > 0) ? q.pop_front() : 8'hxx;
                chk("d1_data", od1, exp_d);
            end
            if (iv1 && ir1) q.push_back(id1);
        end
        iv1 = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
